// File: rtl/snake_grid_engine_if.sv
// Control/query bus between the snake engine, the PS2 command decoder and the VGA controller.
// The master side drives game controls and the raster query; the slave side is the engine.
interface snake_grid_engine_if #(
    parameter int XW = 6,
    parameter int YW = 5,
    parameter int LW = 7
);
    logic          step;
    logic [3:0]    dir;
    logic          start;
    logic          pause;
    logic [XW-1:0] query_x;
    logic [YW-1:0] query_y;
    logic [11:0]   pixel_color_out;
    logic [1:0]    state_out;
    logic [LW-1:0] length_out;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic          died;

    modport master (
        output step, dir, start, pause, query_x, query_y,
        input  pixel_color_out, state_out, length_out, head_x, head_y, died
    );

    modport slave (
        input  step, dir, start, pause, query_x, query_y,
        output pixel_color_out, state_out, length_out, head_x, head_y, died
    );
endinterface

// File: rtl/snake_grid_engine.sv
// Snake game state: circular segment buffer plus occupancy bitmap on a GRID_W x GRID_H grid.
// Optional SNAKE_WRAP_EN: walls wrap around instead of killing the snake.
module snake_grid_engine #(
    parameter int          GRID_W      = 40,
    parameter int          GRID_H      = 30,
    parameter int          MAX_LEN     = 64,
    parameter int          GROW_PERIOD = 8,
    parameter logic [11:0] C_HEAD      = 12'hFF0,
    parameter logic [11:0] C_BODY      = 12'h0F0,
    parameter logic [11:0] C_BG        = 12'h000,
    parameter logic [11:0] C_DEAD      = 12'hF00
) (
    input  logic               clock,
    input  logic               reset_n,
    snake_grid_engine_if.slave bus
);
    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int PW    = $clog2(MAX_LEN);
    localparam int GW    = $clog2(GROW_PERIOD + 1);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int CW    = $clog2(CELLS);

    localparam logic [XW-1:0]    START_X     = XW'(GRID_W / 2);
    localparam logic [YW-1:0]    START_Y     = YW'(GRID_H / 2);
    localparam logic [XW-1:0]    LAST_X      = XW'(GRID_W - 1);
    localparam logic [YW-1:0]    LAST_Y      = YW'(GRID_H - 1);
    localparam logic [PW-1:0]    LAST_PTR    = PW'(MAX_LEN - 1);
    localparam logic [GW-1:0]    LAST_GROW   = GW'(GROW_PERIOD - 1);
    localparam logic [LW-1:0]    MAX_LEN_L   = LW'(MAX_LEN);
    localparam int               START_IDX   = (GRID_H / 2) * GRID_W + (GRID_W / 2);
    localparam logic [CELLS-1:0] BITMAP_INIT = CELLS'(1) << START_IDX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        H_UP    = 2'd0,
        H_DOWN  = 2'd1,
        H_LEFT  = 2'd2,
        H_RIGHT = 2'd3
    } heading_t;

    function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return CW'(int'(y) * GRID_W + int'(x));
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    state_t           state_q, state_d;
    heading_t         heading_q, heading_d;
    heading_t         last_heading_q, last_heading_d;
    heading_t         dir_cand, heading_eff;
    logic [LW-1:0]    length_q, length_d;
    logic [PW-1:0]    head_ptr_q, head_ptr_d;
    logic [PW-1:0]    tail_ptr_q, tail_ptr_d;
    logic [GW-1:0]    grow_cnt_q, grow_cnt_d;
    logic [XW-1:0]    head_x_q, head_x_d;
    logic [YW-1:0]    head_y_q, head_y_d;
    logic [CELLS-1:0] bitmap_q, bitmap_d;
    logic [11:0]      pixel_q, pixel_d;
    logic             died_q, died_d;

    logic [XW-1:0]    seg_x_q [MAX_LEN];
    logic [YW-1:0]    seg_y_q [MAX_LEN];
    logic             seg_we;
    logic [PW-1:0]    seg_waddr;
    logic [XW-1:0]    seg_wx;
    logic [YW-1:0]    seg_wy;

    logic [XW-1:0]    next_x, tail_x;
    logic [YW-1:0]    next_y, tail_y;
    logic [CW-1:0]    next_idx, tail_idx, query_idx;
    logic             dir_valid, dir_reverse;
    logic             off_grid, wall_fatal, grow, hit, fatal;
    logic             step_go, reinit, query_in;

    assign tail_x    = seg_x_q[tail_ptr_q];
    assign tail_y    = seg_y_q[tail_ptr_q];
    assign next_idx  = cell_idx(next_x, next_y);
    assign tail_idx  = cell_idx(tail_x, tail_y);
    assign query_idx = cell_idx(bus.query_x, bus.query_y);

    // Highest-priority direction bit wins; a U-turn is dropped once the snake has a body.
    always_comb begin
        dir_valid = |bus.dir;
        dir_cand  = H_RIGHT;
        if (bus.dir[0]) begin
            dir_cand = H_UP;
        end else if (bus.dir[1]) begin
            dir_cand = H_DOWN;
        end else if (bus.dir[2]) begin
            dir_cand = H_LEFT;
        end
        dir_reverse = (length_q > LW'(1)) && (dir_cand == heading_t'(last_heading_q ^ 2'b01));
        heading_eff = (dir_valid && !dir_reverse) ? dir_cand : heading_q;
    end

    always_comb begin
        next_x   = head_x_q;
        next_y   = head_y_q;
        off_grid = 1'b0;
        unique case (heading_eff)
            H_UP: begin
                off_grid = (head_y_q == '0);
                next_y   = off_grid ? LAST_Y : head_y_q - 1'b1;
            end
            H_DOWN: begin
                off_grid = (head_y_q == LAST_Y);
                next_y   = off_grid ? '0 : head_y_q + 1'b1;
            end
            H_LEFT: begin
                off_grid = (head_x_q == '0);
                next_x   = off_grid ? LAST_X : head_x_q - 1'b1;
            end
            H_RIGHT: begin
                off_grid = (head_x_q == LAST_X);
                next_x   = off_grid ? '0 : head_x_q + 1'b1;
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall_fatal = 1'b0;
`else
    assign wall_fatal = off_grid;
`endif

    // The tail cell is free to enter only when it is about to vacate (no growth this step).
    always_comb begin
        grow    = (grow_cnt_q == LAST_GROW) && (length_q < MAX_LEN_L);
        hit     = bitmap_q[next_idx] && !((next_idx == tail_idx) && !grow);
        fatal   = wall_fatal || hit;
        step_go = (state_q == ST_RUN) && bus.step && !bus.pause;
        reinit  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DEAD));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.pause) begin
                    state_d = ST_PAUSE;
                end else if (bus.step && fatal) begin
                    state_d = ST_DEAD;
                end
            end
            ST_PAUSE: begin
                if (bus.pause) state_d = ST_RUN;
            end
            ST_DEAD: begin
                if (bus.start) state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        bus.state_out       = state_q;
        bus.length_out      = length_q;
        bus.head_x          = head_x_q;
        bus.head_y          = head_y_q;
        bus.died            = died_q;
        bus.pixel_color_out = pixel_q;
    end

    // A fatal step only raises died; the snake itself is left exactly as it was.
    always_comb begin
        heading_d      = heading_eff;
        last_heading_d = last_heading_q;
        length_d       = length_q;
        head_ptr_d     = head_ptr_q;
        tail_ptr_d     = tail_ptr_q;
        grow_cnt_d     = grow_cnt_q;
        head_x_d       = head_x_q;
        head_y_d       = head_y_q;
        bitmap_d       = bitmap_q;
        died_d         = 1'b0;
        seg_we         = 1'b0;
        seg_waddr      = ptr_inc(head_ptr_q);
        seg_wx         = next_x;
        seg_wy         = next_y;

        if (reinit) begin
            heading_d      = H_RIGHT;
            last_heading_d = H_RIGHT;
            length_d       = LW'(1);
            head_ptr_d     = '0;
            tail_ptr_d     = '0;
            grow_cnt_d     = '0;
            head_x_d       = START_X;
            head_y_d       = START_Y;
            bitmap_d       = BITMAP_INIT;
            seg_we         = 1'b1;
            seg_waddr      = '0;
            seg_wx         = START_X;
            seg_wy         = START_Y;
        end else if (step_go) begin
            if (fatal) begin
                died_d = 1'b1;
            end else begin
                seg_we         = 1'b1;
                head_ptr_d     = ptr_inc(head_ptr_q);
                head_x_d       = next_x;
                head_y_d       = next_y;
                last_heading_d = heading_eff;
                grow_cnt_d     = (grow_cnt_q == LAST_GROW) ? '0 : grow_cnt_q + 1'b1;
                if (grow) begin
                    length_d = length_q + 1'b1;
                end else begin
                    bitmap_d[tail_idx] = 1'b0;
                    tail_ptr_d         = ptr_inc(tail_ptr_q);
                end
                bitmap_d[next_idx] = 1'b1;
            end
        end
    end

    // The query always sees the bitmap as it stood before this cycle's step.
    always_comb begin
        query_in = (int'(bus.query_x) < GRID_W) && (int'(bus.query_y) < GRID_H);
        pixel_d  = C_BG;
        if (query_in && bitmap_q[query_idx]) begin
            if (state_q == ST_DEAD) begin
                pixel_d = C_DEAD;
            end else if ((bus.query_x == head_x_q) && (bus.query_y == head_y_q)) begin
                pixel_d = C_HEAD;
            end else begin
                pixel_d = C_BODY;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            heading_q      <= H_RIGHT;
            last_heading_q <= H_RIGHT;
            length_q       <= LW'(1);
            head_ptr_q     <= '0;
            tail_ptr_q     <= '0;
            grow_cnt_q     <= '0;
            head_x_q       <= START_X;
            head_y_q       <= START_Y;
            bitmap_q       <= BITMAP_INIT;
            pixel_q        <= C_BG;
            died_q         <= 1'b0;
        end else begin
            heading_q      <= heading_d;
            last_heading_q <= last_heading_d;
            length_q       <= length_d;
            head_ptr_q     <= head_ptr_d;
            tail_ptr_q     <= tail_ptr_d;
            grow_cnt_q     <= grow_cnt_d;
            head_x_q       <= head_x_d;
            head_y_q       <= head_y_d;
            bitmap_q       <= bitmap_d;
            pixel_q        <= pixel_d;
            died_q         <= died_d;
        end
    end

    // Segment storage needs no reset: every path into RUN writes slot 0 first.
    always_ff @(posedge clock) begin
        if (seg_we) begin
            seg_x_q[seg_waddr] <= seg_wx;
            seg_y_q[seg_waddr] <= seg_wy;
        end
    end
endmodule
